// File: rtl/tohost_pkg.sv
// Shared constants and types for the tohost exit decoder.
package tohost_pkg;

    // tohost word layout
    localparam int unsigned DATA_W      = 64;
    localparam int unsigned CHAR_W      = 8;
    localparam int unsigned DEV_MSB     = 63;
    localparam int unsigned DEV_LSB     = 56;
    localparam int unsigned CMD_MSB     = 55;
    localparam int unsigned CMD_LSB     = 48;
    localparam int unsigned PAYLOAD_MSB = 47;
    localparam int unsigned PAYLOAD_LSB = 0;

    // Device and command codes
    localparam logic [7:0] DEV_SYS  = 8'd0;
    localparam logic [7:0] DEV_CONS = 8'd1;
    localparam logic [7:0] CMD_PUTC = 8'd1;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_e;

endpackage

// File: rtl/tohost_char_queue.sv
// Small DEPTH x CHAR_W FIFO buffering console characters.
module tohost_char_queue
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
)
(
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    pop_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int unsigned CNT_W = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tohost_exit_decoder.sv
// Decodes tohost writes into a sticky pass/fail outcome, forwards console
// characters and fails the test if the DUT stops writing.
module tohost_exit_decoder
#(
    parameter int unsigned CODE_W      = 32,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned WDOG_CYCLES = 0
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       in_data,
    output logic              io_success,
    output logic              io_failure,
    output logic [CODE_W-1:0] io_exit_code,
    output logic              io_timeout,
    output logic              cons_valid,
    input  logic              cons_ready,
    output logic [7:0]        cons_data
);

    import tohost_pkg::*;

    localparam int unsigned QCNT_W  = $clog2(DEPTH) + 1;
    localparam bit          WDOG_EN = (WDOG_CYCLES != 0);
    localparam int unsigned CNT_W   = WDOG_EN ? $clog2(WDOG_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] WDOG_MAX  = CNT_W'(WDOG_CYCLES);
    localparam logic [CNT_W-1:0] WDOG_LAST = WDOG_EN ? CNT_W'(WDOG_CYCLES - 1) : '0;

    state_e             state, state_n;
    logic               success_n, failure_n, timeout_n;
    logic [CODE_W-1:0]  code_n;
    logic [CNT_W-1:0]   wdog_cnt, cnt_n;
    logic               push;
    logic               accept;
    logic               is_exit, is_putc;
    logic [7:0]         dev, cmd;
    logic [CODE_W-1:0]  exit_code;
    logic               q_full, q_empty;
    logic [QCNT_W-1:0]  q_count;
    logic               payload_unused;

    assign dev            = in_data[DEV_MSB:DEV_LSB];
    assign cmd            = in_data[CMD_MSB:CMD_LSB];
    assign exit_code      = in_data[CODE_W:1];
    assign is_exit        = (dev == DEV_SYS) && in_data[0];
    assign is_putc        = (dev == DEV_CONS) && (cmd == CMD_PUTC);
    assign payload_unused = ^in_data[PAYLOAD_MSB:PAYLOAD_LSB];

    // Ready uses the pre-pop occupancy, so a full queue stalls even while draining.
    assign in_ready   = !reset && ((state == DONE) || (q_count != QCNT_W'(DEPTH)));
    assign accept     = in_valid && in_ready;
    assign cons_valid = !q_empty;

    // Next-state, outcome and watchdog decode.
    always_comb begin
        state_n   = state;
        success_n = io_success;
        failure_n = io_failure;
        timeout_n = io_timeout;
        code_n    = io_exit_code;
        cnt_n     = wdog_cnt;
        push      = 1'b0;
        if (state == RUN) begin
            if (accept) begin
                cnt_n = '0;
                if (is_exit) begin
                    state_n = DONE;
                    if (exit_code == '0) begin
                        success_n = 1'b1;
                    end else begin
                        failure_n = 1'b1;
                        code_n    = exit_code;
                    end
                end else if (is_putc) begin
                    push = !q_full;
                end else begin
                    state_n   = DONE;
                    failure_n = 1'b1;
                    code_n    = '1;
                end
            end else if (WDOG_EN) begin
                if (wdog_cnt == WDOG_LAST) begin
                    state_n   = DONE;
                    failure_n = 1'b1;
                    timeout_n = 1'b1;
                    code_n    = '1;
                    cnt_n     = WDOG_MAX;
                end else begin
                    cnt_n = wdog_cnt + CNT_W'(1);
                end
            end
        end else if (WDOG_EN && (wdog_cnt != WDOG_MAX)) begin
            cnt_n = wdog_cnt + CNT_W'(1);
        end
    end

    // State, sticky outcome and watchdog registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= RUN;
            io_success   <= 1'b0;
            io_failure   <= 1'b0;
            io_timeout   <= 1'b0;
            io_exit_code <= '0;
            wdog_cnt     <= '0;
        end else begin
            state        <= state_n;
            io_success   <= success_n;
            io_failure   <= failure_n;
            io_timeout   <= timeout_n;
            io_exit_code <= code_n;
            wdog_cnt     <= cnt_n;
        end
    end

    tohost_char_queue #(.DEPTH(DEPTH)) u_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (in_data[7:0]),
        .pop       (cons_ready),
        .pop_data  (cons_data),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

endmodule

// File: tb/tb_tohost_exit_decoder.sv
// Directed bench for tohost_exit_decoder: decode table plus console,
// backpressure, DONE-state and watchdog sequences.
module tb_tohost_exit_decoder;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        io_success, io_failure, io_timeout;
    logic [31:0] io_exit_code;
    logic        cons_valid, cons_ready;
    logic [7:0]  cons_data;

    logic        w_reset, w_in_valid, w_in_ready;
    logic [63:0] w_in_data;
    logic        w_io_success, w_io_failure, w_io_timeout;
    logic [31:0] w_io_exit_code;
    logic        w_cons_valid, w_cons_ready;
    logic [7:0]  w_cons_data;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    tohost_exit_decoder #(.CODE_W(32), .DEPTH(4), .WDOG_CYCLES(0)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .io_success(io_success), .io_failure(io_failure),
        .io_exit_code(io_exit_code), .io_timeout(io_timeout),
        .cons_valid(cons_valid), .cons_ready(cons_ready), .cons_data(cons_data)
    );

    tohost_exit_decoder #(.CODE_W(32), .DEPTH(4), .WDOG_CYCLES(10)) dut_wdog (
        .clock(clock), .reset(w_reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_data(w_in_data), .io_success(w_io_success), .io_failure(w_io_failure),
        .io_exit_code(w_io_exit_code), .io_timeout(w_io_timeout),
        .cons_valid(w_cons_valid), .cons_ready(w_cons_ready), .cons_data(w_cons_data)
    );

    typedef struct {
        logic [63:0] data;
        logic        succ;
        logic        fail;
        logic [31:0] code;
        logic        cv;
        logic [7:0]  cd;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Offer one word and wait (bounded) for it to be accepted; returns #1 after the edge.
    task automatic send(input logic [63:0] d, input int budget, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (in_ready) begin
                @(posedge clock);
                #1;
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        bit ok;

        reset        = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        cons_ready   = 1'b0;
        w_reset      = 1'b1;
        w_in_valid   = 1'b0;
        w_in_data    = '0;
        w_cons_ready = 1'b1;

        vecs[0]  = '{64'h0000_0000_0000_0001, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 8'h00};
        vecs[1]  = '{64'h0000_0000_0000_0007, 1'b0, 1'b1, 32'h0000_0003, 1'b0, 8'h00};
        vecs[2]  = '{64'h0205_0000_0000_0000, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 8'h00};
        vecs[3]  = '{64'h0000_0000_0000_0000, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 8'h00};
        vecs[4]  = '{64'h0000_0001_0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 8'h00};
        vecs[5]  = '{64'h0000_0002_0000_0001, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 8'h00};
        vecs[6]  = '{64'h0101_0000_0000_0041, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 8'h41};
        vecs[7]  = '{64'h0102_0000_0000_0041, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 8'h00};
        vecs[8]  = '{64'h0100_0000_0000_0041, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 8'h00};
        vecs[9]  = '{64'h00FF_0000_0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b0, 8'h00};
        vecs[10] = '{64'h0101_FFFF_FFFF_FF7E, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 8'h7E};

        // Reset values while reset is held
        repeat (2) @(posedge clock);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_success", io_success, 0);
        chk("rst_failure", io_failure, 0);
        chk("rst_timeout", io_timeout, 0);
        chk("rst_code", io_exit_code, 0);
        chk("rst_cons_valid", cons_valid, 0);
        reset = 1'b0;

        // Single-word decode table
        for (int i = 0; i < NVEC; i++) begin
            cons_ready = 1'b0;
            do_reset();
            send(vecs[i].data, 8, ok);
            chk($sformatf("vec%0d_accept", i), ok, 1);
            chk($sformatf("vec%0d_success", i), io_success, vecs[i].succ);
            chk($sformatf("vec%0d_failure", i), io_failure, vecs[i].fail);
            chk($sformatf("vec%0d_code", i), io_exit_code, vecs[i].code);
            chk($sformatf("vec%0d_timeout", i), io_timeout, 0);
            chk($sformatf("vec%0d_cons_valid", i), cons_valid, vecs[i].cv);
            if (vecs[i].cv) chk($sformatf("vec%0d_cons_data", i), cons_data, vecs[i].cd);
        end

        // DONE sinks and ignores later words, including console writes
        cons_ready = 1'b0;
        do_reset();
        send(64'h0000_0000_0000_0001, 8, ok);
        send(64'h0000_0000_0000_0007, 8, ok);
        chk("done_accept_exit", ok, 1);
        chk("done_success", io_success, 1);
        chk("done_failure", io_failure, 0);
        chk("done_code", io_exit_code, 0);
        send(64'h0101_0000_0000_0041, 8, ok);
        chk("done_accept_putc", ok, 1);
        chk("done_putc_dropped", cons_valid, 0);

        // Console stream with an always-ready sink
        cons_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            send(64'h0101_0000_0000_0041 + 64'(k), 8, ok);
            chk($sformatf("stream%0d_accept", k), ok, 1);
            chk($sformatf("stream%0d_valid", k), cons_valid, 1);
            chk($sformatf("stream%0d_data", k), cons_data, 8'h41 + 8'(k));
        end
        @(posedge clock); #1;
        chk("stream_drained", cons_valid, 0);

        // Backpressure: four fill the queue, fifth waits for one pop
        cons_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send(64'h0101_0000_0000_0042 + 64'(k), 8, ok);
            chk($sformatf("fill%0d_accept", k), ok, 1);
        end
        in_valid = 1'b1;
        in_data  = 64'h0101_0000_0000_0046;
        @(negedge clock);
        chk("full_in_ready", in_ready, 0);
        cons_ready = 1'b1;
        @(posedge clock); #1;
        cons_ready = 1'b0;
        chk("after_pop_in_ready", in_ready, 1);
        chk("after_pop_head", cons_data, 8'h43);
        @(posedge clock); #1;
        in_valid = 1'b0;
        cons_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d_valid", k), cons_valid, 1);
            chk($sformatf("drain%0d_data", k), cons_data, 8'h43 + 8'(k));
            @(posedge clock); #1;
        end
        chk("drain_empty", cons_valid, 0);

        // Exit while characters are queued; queue still drains in DONE
        cons_ready = 1'b0;
        do_reset();
        send(64'h0101_0000_0000_0041, 8, ok);
        send(64'h0000_0000_0000_0001, 8, ok);
        chk("exitq_success", io_success, 1);
        chk("exitq_valid", cons_valid, 1);
        chk("exitq_data", cons_data, 8'h41);
        cons_ready = 1'b1;
        @(posedge clock); #1;
        chk("exitq_drained", cons_valid, 0);

        // Reset mid-test clears queued characters
        cons_ready = 1'b0;
        do_reset();
        send(64'h0101_0000_0000_0041, 8, ok);
        send(64'h0101_0000_0000_0042, 8, ok);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("midrst_cons_valid", cons_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        reset = 1'b0;

        // Watchdog expiry after ten idle RUN cycles
        w_reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 w_reset = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        chk("wdog9_failure", w_io_failure, 0);
        @(posedge clock); #1;
        chk("wdog10_failure", w_io_failure, 1);
        chk("wdog10_timeout", w_io_timeout, 1);
        chk("wdog10_code", w_io_exit_code, 32'hFFFF_FFFF);
        chk("wdog10_success", w_io_success, 0);
        chk("wdog_done_ready", w_in_ready, 1);

        // A write on the tenth cycle clears the count instead
        w_reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 w_reset = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        w_in_valid = 1'b1;
        w_in_data  = 64'h0101_0000_0000_005A;
        chk("wdog_write_ready", w_in_ready, 1);
        @(posedge clock); #1;
        w_in_valid = 1'b0;
        chk("wdog_write_nofail", w_io_failure, 0);
        repeat (9) @(posedge clock);
        #1;
        chk("wdog_rearm9_failure", w_io_failure, 0);
        @(posedge clock); #1;
        chk("wdog_rearm10_failure", w_io_failure, 1);
        chk("wdog_rearm10_timeout", w_io_timeout, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
